// File: rtl/eth_bfm_pkg.sv
// Shared constants, state encodings and CRC helper for the GMII/MDIO PHY board model.
package eth_bfm_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam int unsigned MIN_FRAME_LEN = 64;
    localparam int unsigned MAX_PREAMBLE  = 7;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned MDIO_PRE_LEN  = 32;

    localparam logic [15:0] MDIO_REG0_RST = 16'h1140;
    localparam logic [15:0] MDIO_REG1_RST = 16'h796D;
    localparam logic [1:0]  MDIO_OP_READ  = 2'b10;
    localparam logic [1:0]  MDIO_OP_WRITE = 2'b01;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_PREAMBLE,
        MON_DATA
    } mon_state_t;

    typedef enum logic [2:0] {
        MDIO_PRE,
        MDIO_ST,
        MDIO_OP,
        MDIO_PHYAD,
        MDIO_REGAD,
        MDIO_TA,
        MDIO_DATA
    } mdio_state_t;

    // Reflected CRC-32, one byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int unsigned k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_bfm_port.sv
// One PHY port: GMII loopback, transmit frame monitor and Clause-22 MDIO slave.
module eth_bfm_port
    import eth_bfm_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [31:0] PHY_ID   = 32'h5000_0000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [7:0] txd,
    input  logic       txen,
    input  logic       txer,
    output logic [7:0] rxd,
    output logic       rxdv,
    output logic       rxer,
    input  logic       mdc_rise,
    input  logic       mdc_fall,
    input  logic       mdio_in,
    output logic       mdio_en,
    output logic       mdio_out,
    output logic       err_c
);

    localparam int unsigned NUM_REGS = 32;

    function automatic logic [15:0] reg_reset(input logic [4:0] addr);
        case (addr)
            5'd0:    return MDIO_REG0_RST;
            5'd1:    return MDIO_REG1_RST;
            5'd2:    return PHY_ID[31:16];
            5'd3:    return PHY_ID[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    logic [7:0]       rxd_q, rxd_d;
    logic             rxdv_q, rxdv_d, rxer_q, rxer_d;
    mon_state_t       mon_state_q, mon_state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;

    mdio_state_t      mdio_state_q, mdio_state_d;
    logic [5:0]       mdio_pre_q, mdio_pre_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       phyad_q, phyad_d, regad_q, regad_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             mdio_en_q, mdio_en_d, mdio_out_q, mdio_out_d;
    logic [15:0]      regs_q [NUM_REGS];
    logic [15:0]      regs_d [NUM_REGS];

    logic [15:0] rdata;
    logic        rd_match, wr_match;

    assign rxd      = rxd_q;
    assign rxdv     = rxdv_q;
    assign rxer     = rxer_q;
    assign mdio_en  = mdio_en_q;
    assign mdio_out = mdio_out_q;

    assign rdata    = regs_q[regad_q];
    assign rd_match = (op_q == MDIO_OP_READ)  && (phyad_q == PHY_ADDR);
    assign wr_match = (op_q == MDIO_OP_WRITE) && (phyad_q == PHY_ADDR);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rxd_q        <= '0;
            rxdv_q       <= 1'b0;
            rxer_q       <= 1'b0;
            mon_state_q  <= MON_IDLE;
            pre_cnt_q    <= '0;
            crc_q        <= CRC32_INIT;
            len_q        <= '0;
            mdio_state_q <= MDIO_PRE;
            mdio_pre_q   <= '0;
            bit_cnt_q    <= '0;
            op_q         <= '0;
            phyad_q      <= '0;
            regad_q      <= '0;
            wdata_q      <= '0;
            mdio_en_q    <= 1'b0;
            mdio_out_q   <= 1'b1;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_reset(5'(i));
        end else begin
            rxd_q        <= rxd_d;
            rxdv_q       <= rxdv_d;
            rxer_q       <= rxer_d;
            mon_state_q  <= mon_state_d;
            pre_cnt_q    <= pre_cnt_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            mdio_state_q <= mdio_state_d;
            mdio_pre_q   <= mdio_pre_d;
            bit_cnt_q    <= bit_cnt_d;
            op_q         <= op_d;
            phyad_q      <= phyad_d;
            regad_q      <= regad_d;
            wdata_q      <= wdata_d;
            mdio_en_q    <= mdio_en_d;
            mdio_out_q   <= mdio_out_d;
            regs_q       <= regs_d;
        end
    end

    // Loopback plus frame monitor; rxdv_q doubles as the previous txen for edge detection.
    always_comb begin
        rxd_d       = txd;
        rxdv_d      = txen;
        rxer_d      = txer;
        mon_state_d = mon_state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        err_c       = 1'b0;
        unique case (mon_state_q)
            MON_IDLE: begin
                if (txen && !rxdv_q) begin
                    if (txd == GMII_PREAMBLE) begin
                        mon_state_d = MON_PREAMBLE;
                        pre_cnt_d   = 3'd1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            MON_PREAMBLE: begin
                if (!txen) begin
                    err_c       = 1'b1;
                    mon_state_d = MON_IDLE;
                end else if (txd == GMII_SFD) begin
                    mon_state_d = MON_DATA;
                    crc_d       = CRC32_INIT;
                    len_d       = '0;
                end else if (txd == GMII_PREAMBLE && pre_cnt_q < 3'(MAX_PREAMBLE)) begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end else begin
                    err_c       = 1'b1;
                    mon_state_d = MON_IDLE;
                end
            end
            MON_DATA: begin
                if (txen) begin
                    crc_d = crc32_byte(crc_q, txd);
                    if (len_q != '1) len_d = len_q + LEN_W'(1);
                end else begin
                    mon_state_d = MON_IDLE;
                    if (crc_q != CRC32_RESIDUE || len_q < LEN_W'(MIN_FRAME_LEN)) err_c = 1'b1;
                end
            end
            default: mon_state_d = MON_IDLE;
        endcase
        if (txen && txer) err_c = 1'b1;
    end

    // MDIO slave: shift on mdc_rise, drive on mdc_fall.
    always_comb begin
        mdio_state_d = mdio_state_q;
        mdio_pre_d   = mdio_pre_q;
        bit_cnt_d    = bit_cnt_q;
        op_d         = op_q;
        phyad_d      = phyad_q;
        regad_d      = regad_q;
        wdata_d      = wdata_q;
        mdio_en_d    = mdio_en_q;
        mdio_out_d   = mdio_out_q;
        regs_d       = regs_q;
        if (mdc_rise) begin
            unique case (mdio_state_q)
                MDIO_PRE: begin
                    if (mdio_in) begin
                        if (mdio_pre_q < 6'(MDIO_PRE_LEN)) mdio_pre_d = mdio_pre_q + 6'd1;
                    end else if (mdio_pre_q == 6'(MDIO_PRE_LEN)) begin
                        mdio_state_d = MDIO_ST;
                    end else begin
                        mdio_pre_d = '0;
                    end
                end
                MDIO_ST: begin
                    mdio_pre_d = '0;
                    bit_cnt_d  = '0;
                    mdio_state_d = mdio_in ? MDIO_OP : MDIO_PRE;
                end
                MDIO_OP: begin
                    op_d      = {op_q[0], mdio_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d = '0;
                        if (op_d == MDIO_OP_READ || op_d == MDIO_OP_WRITE) mdio_state_d = MDIO_PHYAD;
                        else mdio_state_d = MDIO_PRE;
                    end
                end
                MDIO_PHYAD: begin
                    phyad_d   = {phyad_q[3:0], mdio_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd4) begin
                        bit_cnt_d    = '0;
                        mdio_state_d = MDIO_REGAD;
                    end
                end
                MDIO_REGAD: begin
                    regad_d   = {regad_q[3:0], mdio_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd4) begin
                        bit_cnt_d    = '0;
                        mdio_state_d = MDIO_TA;
                    end
                end
                MDIO_TA: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        bit_cnt_d    = '0;
                        mdio_state_d = MDIO_DATA;
                    end
                end
                MDIO_DATA: begin
                    wdata_d   = {wdata_q[14:0], mdio_in};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d    = '0;
                        mdio_state_d = MDIO_PRE;
                        if (wr_match) begin
                            if (regad_q == 5'd0) begin
                                if (wdata_d[15]) begin
                                    for (int unsigned i = 0; i < 4; i++) regs_d[i] = reg_reset(5'(i));
                                end else begin
                                    regs_d[0] = wdata_d;
                                end
                            end else if (regad_q > 5'd3) begin
                                regs_d[regad_q] = wdata_d;
                            end
                        end
                    end
                end
                default: mdio_state_d = MDIO_PRE;
            endcase
        end
        if (mdc_fall) begin
            mdio_en_d  = 1'b0;
            mdio_out_d = 1'b1;
            if (rd_match && mdio_state_q == MDIO_TA && bit_cnt_q == 4'd1) begin
                mdio_en_d  = 1'b1;
                mdio_out_d = 1'b0;
            end else if (rd_match && mdio_state_q == MDIO_DATA) begin
                mdio_en_d  = 1'b1;
                mdio_out_d = rdata[4'd15 - bit_cnt_q];
            end
        end
    end

endmodule

// File: rtl/eth_gmii_phy_bfm.sv
// Multi-port Ethernet PHY board model: per-port loopback/monitor/MDIO plus a sticky halt flag.
module eth_gmii_phy_bfm
    import eth_bfm_pkg::*;
#(
    parameter int unsigned START_NODE     = 1,
    parameter int unsigned NUM_PORTS      = 4,
    parameter logic [31:0] MDIO_BUFF_ADDR = 32'h5000_0000
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [NUM_PORTS*8-1:0] gmii_txd,
    input  logic [NUM_PORTS-1:0]   gmii_txen,
    input  logic [NUM_PORTS-1:0]   gmii_txer,
    output logic [NUM_PORTS*8-1:0] gmii_rxd,
    output logic [NUM_PORTS-1:0]   gmii_rxdv,
    output logic [NUM_PORTS-1:0]   gmii_rxer,
    input  logic                   mdc,
    inout  wire  [NUM_PORTS-1:0]   mdio,
    output logic [NUM_PORTS-1:0]   mdio_en,
    output logic [NUM_PORTS-1:0]   mdio_out,
    output logic                   halt_req
);

    logic [2:0]           mdc_sync_q, mdc_sync_d;
    logic                 halt_req_q, halt_req_d;
    logic                 mdc_rise, mdc_fall;
    logic [NUM_PORTS-1:0] port_err;

    assign mdc_rise = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign mdc_fall = ~mdc_sync_q[1] & mdc_sync_q[2];
    assign halt_req = halt_req_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mdc_sync_q <= '1;
            halt_req_q <= 1'b0;
        end else begin
            mdc_sync_q <= mdc_sync_d;
            halt_req_q <= halt_req_d;
        end
    end

    always_comb begin
        mdc_sync_d = {mdc_sync_q[1:0], mdc};
        halt_req_d = halt_req_q | (|port_err);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        eth_bfm_port #(
            .PHY_ADDR (5'((START_NODE + p) % 32)),
            .PHY_ID   (MDIO_BUFF_ADDR)
        ) u_port (
            .clk      (clk),
            .arst_n   (arst_n),
            .txd      (gmii_txd[p*8 +: 8]),
            .txen     (gmii_txen[p]),
            .txer     (gmii_txer[p]),
            .rxd      (gmii_rxd[p*8 +: 8]),
            .rxdv     (gmii_rxdv[p]),
            .rxer     (gmii_rxer[p]),
            .mdc_rise (mdc_rise),
            .mdc_fall (mdc_fall),
            .mdio_in  (mdio[p]),
            .mdio_en  (mdio_en[p]),
            .mdio_out (mdio_out[p]),
            .err_c    (port_err[p])
        );

        assign mdio[p] = mdio_en[p] ? mdio_out[p] : 1'bz;
    end

endmodule

// File: tb/tb_eth_gmii_phy_bfm.sv
// Directed bench for eth_gmii_phy_bfm: loopback, frame checks, MDIO read/write/abort/reset.
module tb_eth_gmii_phy_bfm;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [NP*8-1:0] gmii_txd;
    logic [NP-1:0]   gmii_txen, gmii_txer;
    logic [NP*8-1:0] gmii_rxd;
    logic [NP-1:0]   gmii_rxdv, gmii_rxer;
    logic            mdc;
    wire  [NP-1:0]   mdio;
    logic [NP-1:0]   mdio_en, mdio_out;
    logic            halt_req;

    logic [NP-1:0]   host_en, host_out, en_seen;
    logic [7:0]      frm [$];
    int              total = 0;
    int              bad = 0;

    always #4 clk = ~clk;

    for (genvar i = 0; i < NP; i++) begin : g_host
        assign mdio[i] = host_en[i] ? host_out[i] : 1'bz;
    end

    eth_gmii_phy_bfm #(
        .START_NODE     (1),
        .NUM_PORTS      (NP),
        .MDIO_BUFF_ADDR (32'h5000_0000)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .gmii_txd  (gmii_txd),
        .gmii_txen (gmii_txen),
        .gmii_txer (gmii_txer),
        .gmii_rxd  (gmii_rxd),
        .gmii_rxdv (gmii_rxdv),
        .gmii_rxer (gmii_rxer),
        .mdc       (mdc),
        .mdio      (mdio),
        .mdio_en   (mdio_en),
        .mdio_out  (mdio_out),
        .halt_req  (halt_req)
    );

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Preamble, SFD, n payload bytes 0,1,2.. and the FCS (LSB byte first).
    task automatic build_frame(input int n);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 7; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            frm.push_back(8'(i));
            c = crc_step(c, 8'(i));
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    // Drives frm on port p and counts loopback mismatches against the previous cycle's tx.
    task automatic send_frame(input int p, input int er_at, output int lb_err);
        logic [7:0] pd;
        logic       pe, pr;
        pd = 8'h00; pe = 1'b0; pr = 1'b0; lb_err = 0;
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            if (gmii_rxd[p*8 +: 8] !== pd || gmii_rxdv[p] !== pe || gmii_rxer[p] !== pr) lb_err++;
            gmii_txd[p*8 +: 8] = frm[i];
            gmii_txen[p] = 1'b1;
            gmii_txer[p] = (i == er_at);
            pd = frm[i]; pe = 1'b1; pr = (i == er_at);
        end
        @(posedge clk); #1;
        if (gmii_rxd[p*8 +: 8] !== pd || gmii_rxdv[p] !== pe || gmii_rxer[p] !== pr) lb_err++;
        gmii_txd[p*8 +: 8] = 8'h00;
        gmii_txen[p] = 1'b0;
        gmii_txer[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One MDC period (8 clk low, 8 clk high); rd is the line as seen by the master before the rise.
    task automatic mdio_cycle(input int p, input logic drv, input logic val, output logic rd);
        mdc = 1'b0;
        host_en[p] = drv;
        host_out[p] = val;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            en_seen = en_seen | mdio_en;
        end
        rd = mdio_en[p] ? mdio_out[p] : 1'b1;
        mdc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            en_seen = en_seen | mdio_en;
        end
    endtask

    task automatic mdio_frame(input int p, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                              input int nbits, output logic [15:0] rdat, output logic ta2);
        logic [63:0] bits;
        logic        rd, is_rd;
        is_rd = (st == 2'b01) && (op == 2'b10);
        bits  = {32'hFFFF_FFFF, st, op, pa, ra, 2'b10, wd};
        rdat  = 16'h0000;
        ta2   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            mdio_cycle(p, !(is_rd && i >= 46), bits[63-i], rd);
            if (i == 47) ta2 = rd;
            if (i >= 48) rdat[63-i] = rd;
        end
        host_en[p]  = 1'b1;
        host_out[p] = 1'b1;
    endtask

    // Full transaction followed by one idle MDC period so the slave can release the line.
    task automatic mdio_xfer(input int p, input logic [1:0] op, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd,
                             output logic [15:0] rdat, output logic ta2);
        logic rd;
        mdio_frame(p, 2'b01, op, pa, ra, wd, 64, rdat, ta2);
        mdio_cycle(p, 1'b1, 1'b1, rd);
    endtask

    task automatic test_reset();
        logic idle_bad;
        gmii_txd = '0; gmii_txen = '0; gmii_txer = '0;
        mdc = 1'b1; host_en = '1; host_out = '1; en_seen = '0;
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({gmii_rxd, gmii_rxdv, gmii_rxer} !== '0) begin bad++; $display("FAIL reset_rx: got %h exp 0", {gmii_rxd, gmii_rxdv, gmii_rxer}); end
        total++; if (mdio_en !== 4'h0) begin bad++; $display("FAIL reset_mdio_en: got %h exp 0", mdio_en); end
        total++; if (mdio_out !== 4'hF) begin bad++; $display("FAIL reset_mdio_out: got %h exp f", mdio_out); end
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b exp 0", halt_req); end
        arst_n = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if ({gmii_rxd, gmii_rxdv, gmii_rxer} !== '0 || mdio_en !== '0 || halt_req !== 1'b0) idle_bad = 1'b1;
        end
        total++; if (idle_bad !== 1'b0) begin bad++; $display("FAIL idle_1000: got %b exp 0", idle_bad); end
    endtask

    task automatic test_good_frame();
        int lb;
        build_frame(60);
        send_frame(2, -1, lb);
        total++; if (lb !== 0) begin bad++; $display("FAIL good_loopback: got %0d mismatches exp 0", lb); end
        @(posedge clk); #1;
        total++; if (gmii_rxdv[2] !== 1'b0) begin bad++; $display("FAIL good_rxdv_drop: got %b exp 0", gmii_rxdv[2]); end
        repeat (3) @(posedge clk); #1;
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL good_halt: got %b exp 0", halt_req); end
    endtask

    task automatic test_frame_errors();
        int lb;
        build_frame(60);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        send_frame(0, -1, lb);
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL fcs_halt_early: got %b exp 0", halt_req); end
        @(posedge clk); #1;
        total++; if (halt_req !== 1'b1) begin bad++; $display("FAIL fcs_halt: got %b exp 1", halt_req); end
        repeat (5) @(posedge clk); #1;
        total++; if (halt_req !== 1'b1) begin bad++; $display("FAIL fcs_halt_sticky: got %b exp 1", halt_req); end
        do_reset();
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL halt_cleared: got %b exp 0", halt_req); end

        build_frame(40);
        send_frame(3, -1, lb);
        @(posedge clk); #1;
        total++; if (halt_req !== 1'b1) begin bad++; $display("FAIL short_halt: got %b exp 1", halt_req); end
        do_reset();

        build_frame(60);
        send_frame(1, 20, lb);
        total++; if (lb !== 0) begin bad++; $display("FAIL txer_loopback: got %0d mismatches exp 0", lb); end
        total++; if (halt_req !== 1'b1) begin bad++; $display("FAIL txer_halt: got %b exp 1", halt_req); end
        do_reset();
    endtask

    task automatic test_mdio_read_port1();
        logic [15:0] d;
        logic        ta;
        en_seen = '0;
        mdio_xfer(1, 2'b10, 5'd2, 5'd2, 16'h0, d, ta);
        total++; if (d !== 16'h5000) begin bad++; $display("FAIL rd_reg2: got %h exp 5000", d); end
        total++; if (ta !== 1'b0) begin bad++; $display("FAIL rd_ta_zero: got %b exp 0", ta); end
        total++; if (mdio_en[1] !== 1'b0) begin bad++; $display("FAIL rd_release: got %b exp 0", mdio_en[1]); end
        mdio_xfer(1, 2'b10, 5'd2, 5'd3, 16'h0, d, ta);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL rd_reg3: got %h exp 0000", d); end
        mdio_xfer(1, 2'b10, 5'd2, 5'd0, 16'h0, d, ta);
        total++; if (d !== 16'h1140) begin bad++; $display("FAIL rd_reg0: got %h exp 1140", d); end
        total++; if ((en_seen & 4'b1101) !== 4'b0000) begin bad++; $display("FAIL other_ports_quiet: got %b exp 0000", en_seen); end
        total++; if (en_seen[1] !== 1'b1) begin bad++; $display("FAIL port1_drove: got %b exp 1", en_seen[1]); end
    endtask

    task automatic test_mdio_write_port0();
        logic [15:0] d;
        logic        ta;
        mdio_xfer(0, 2'b01, 5'd1, 5'd4, 16'hA5A5, d, ta);
        mdio_xfer(0, 2'b10, 5'd1, 5'd4, 16'h0, d, ta);
        total++; if (d !== 16'hA5A5) begin bad++; $display("FAIL wr_reg4: got %h exp a5a5", d); end
        mdio_xfer(0, 2'b01, 5'd1, 5'd0, 16'h0100, d, ta);
        mdio_xfer(0, 2'b10, 5'd1, 5'd0, 16'h0, d, ta);
        total++; if (d !== 16'h0100) begin bad++; $display("FAIL wr_reg0: got %h exp 0100", d); end
        mdio_xfer(0, 2'b01, 5'd1, 5'd0, 16'h8000, d, ta);
        mdio_xfer(0, 2'b10, 5'd1, 5'd0, 16'h0, d, ta);
        total++; if (d !== 16'h1140) begin bad++; $display("FAIL soft_reset_reg0: got %h exp 1140", d); end
        mdio_xfer(0, 2'b10, 5'd1, 5'd4, 16'h0, d, ta);
        total++; if (d !== 16'hA5A5) begin bad++; $display("FAIL soft_reset_reg4: got %h exp a5a5", d); end
        mdio_xfer(0, 2'b01, 5'd1, 5'd1, 16'h0000, d, ta);
        mdio_xfer(0, 2'b10, 5'd1, 5'd1, 16'h0, d, ta);
        total++; if (d !== 16'h796D) begin bad++; $display("FAIL ro_reg1: got %h exp 796d", d); end
        mdio_xfer(0, 2'b01, 5'd5, 5'd6, 16'h1234, d, ta);
        mdio_xfer(0, 2'b10, 5'd1, 5'd6, 16'h0, d, ta);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL wrong_phyad_write: got %h exp 0000", d); end
    endtask

    task automatic test_mdio_abort();
        logic [15:0] d;
        logic        ta, rd;
        en_seen = '0;
        mdio_frame(0, 2'b00, 2'b01, 5'd1, 5'd4, 16'h0000, 64, d, ta);
        mdio_cycle(0, 1'b1, 1'b1, rd);
        mdio_frame(0, 2'b00, 2'b10, 5'd1, 5'd2, 16'h0000, 64, d, ta);
        mdio_cycle(0, 1'b1, 1'b1, rd);
        total++; if (en_seen !== 4'b0000) begin bad++; $display("FAIL abort_no_drive: got %b exp 0000", en_seen); end
        mdio_xfer(0, 2'b10, 5'd1, 5'd4, 16'h0, d, ta);
        total++; if (d !== 16'hA5A5) begin bad++; $display("FAIL abort_no_write: got %h exp a5a5", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] d;
        logic        ta;
        mdio_frame(1, 2'b01, 2'b10, 5'd2, 5'd2, 16'h0, 53, d, ta);
        total++; if (mdio_en[1] !== 1'b1) begin bad++; $display("FAIL midread_driving: got %b exp 1", mdio_en[1]); end
        arst_n = 1'b0;
        #1;
        total++; if (mdio_en[1] !== 1'b0) begin bad++; $display("FAIL midread_async_release: got %b exp 0", mdio_en[1]); end
        total++; if (mdio_out[1] !== 1'b1) begin bad++; $display("FAIL midread_out_idle: got %b exp 1", mdio_out[1]); end
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        mdio_xfer(1, 2'b10, 5'd2, 5'd2, 16'h0, d, ta);
        total++; if (d !== 16'h5000) begin bad++; $display("FAIL post_reset_reg2: got %h exp 5000", d); end
        mdio_xfer(0, 2'b10, 5'd1, 5'd4, 16'h0, d, ta);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL post_reset_reg4: got %h exp 0000", d); end
        total++; if (halt_req !== 1'b0) begin bad++; $display("FAIL mdio_no_halt: got %b exp 0", halt_req); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_errors();
        test_mdio_read_port1();
        test_mdio_write_port0();
        test_mdio_abort();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_gmii_phy_bfm.md
Name: eth_gmii_phy_bfm

Overview:
Behavioural model of a multi-port Ethernet PHY board environment that sits outside the FPGA top level. Each port does three things:
- loops the DUT's GMII transmit stream back onto its GMII receive pins;
- checks every transmitted frame (preamble, SFD, length, FCS);
- models a Clause-22 MDIO PHY register file.

A sticky halt request flags any protocol error so the bench can stop simulation.

Parameters:
START_NODE, 1, PHY address of port 0; port p answers PHYAD = (START_NODE+p) mod 32
NUM_PORTS, 4, number of GMII/MDIO ports (1..8)
MDIO_BUFF_ADDR, 32'h5000_0000, reset contents of PHY ID regs: reg2 = [31:16], reg3 = [15:0]

Ports:
clk  in  1  GMII clock (125 MHz); all logic on rising edge
arst_n  in  1  asynchronous active-low reset
gmii_txd  in  NUM_PORTS x 8  DUT transmit data per port
gmii_txen  in  NUM_PORTS  DUT transmit enable
gmii_txer  in  NUM_PORTS  DUT transmit error
gmii_rxd  out  NUM_PORTS x 8  receive data toward DUT
gmii_rxdv  out  NUM_PORTS  receive data valid
gmii_rxer  out  NUM_PORTS  receive error
mdc  in  1  shared MDIO clock from DUT; sampled, not used as a clock
mdio  inout  NUM_PORTS  per-port MDIO line; external pull-up assumed
mdio_en  out  NUM_PORTS  BFM drives mdio[p] when 1 (2-state simulator path)
mdio_out  out  NUM_PORTS  value driven when mdio_en=1
halt_req  out  1  sticky error flag

Behaviour:
- Reset values: all rx outputs 0; mdio_en 0; mdio_out 1; mdio released (Z); halt_req 0; register files restored to reset values.
- Reset is asynchronous and may assert mid-frame or mid-MDIO transaction. On release, every FSM is in IDLE and any partial frame is discarded without an error.

Loopback:
- gmii_rxd/rxdv/rxer[p] are gmii_txd/txen/txer[p] registered once (1-cycle latency).

Frame monitor, per port:
- States: IDLE, PREAMBLE, DATA.
- IDLE -> PREAMBLE on txen rising.
- PREAMBLE expects 0x55 bytes, then 0xD5 (SFD).
  - Accept 1..7 bytes of 0x55 before the SFD.
  - Any other byte = error.
  - txen falling before the SFD = error.
- DATA: run CRC-32 over bytes after the SFD.
  - Reflected polynomial 0xEDB88320, register init 0xFFFF_FFFF.
  - Count bytes, saturating at 2047.
- On txen falling in DATA, flag an error if either:
  - the CRC register is not 0xDEBB_20E3, or
  - byte count < 64.
  Then return to IDLE.
- txer=1 while txen=1 = error.
- Any error sets halt_req = 1 on the next clk edge. It stays 1 until reset.

MDIO sampling:
- mdc passes through a 2-flop synchronizer; edge detect gives mdc_rise and mdc_fall pulses.
- mdio is sampled on mdc_rise.
- The BFM changes mdio_en/mdio_out only on mdc_fall.

MDIO slave, per port:
- States: PRE, ST, OP, PHYAD, REGAD, TA, DATA.
- PRE: needs ≥32 consecutive 1 samples. Then ST must be 01; otherwise return to PRE and clear the preamble count.
- OP: 10 = read, 01 = write; any other value aborts to PRE.
- PHYAD and REGAD: 5 bits each, MSB first.
- Address mismatch: stay passive, never drive the line; skip to PRE after the frame's remaining bits.
- Read with address match:
  - mdio_en = 1 and mdio_out = 0 from the mdc_fall after the first TA sample (second TA bit).
  - Then 16 data bits MSB first, each updated on mdc_fall.
  - Release (mdio_en = 0) on the mdc_fall after bit 0.
- Write with address match: TA bits are ignored; capture 16 bits; commit on the last mdc_rise.
- Back-to-back transactions must each have a full 32-bit preamble.

Register file, per port (32 x 16):
- reg0 control, reset 0x1140. Writing bit15 = 1 reloads reg0..3 to reset values; bit15 then reads 0 (self-clearing).
- reg1 status, reset 0x796D, read-only.
- reg2/reg3 PHY ID from MDIO_BUFF_ADDR, read-only.
- reg4..31 reset 0x0000, read/write.

Tri-state:
- mdio[p] = mdio_en[p] ? mdio_out[p] : Z.
- The mdio_en/mdio_out pair is always present so 2-state tools can resolve the bus externally.

Decomposition:
- Package eth_bfm_pkg:
  - CRC32_POLY, CRC32_RESIDUE, GMII_PREAMBLE, GMII_SFD, MIN_FRAME_LEN
  - MDIO register reset constants
  - mdio_state_t and mon_state_t enums
  - crc32_byte() function
- One sub-module, eth_bfm_port: loopback, monitor and MDIO slave for one port.
- Top generates NUM_PORTS instances, the shared mdc synchronizer, and the OR of per-port errors into halt_req.

Test Plan:
- Reset, idle: no txen for 1000 cycles -> all rx outputs 0, mdio_en 0, halt_req 0.
- Good frame: 7x0x55, 0xD5, 60 bytes 0x00..0x3B plus correct FCS -> rxd equals txd delayed 1 cycle; halt_req stays 0.
- FCS fault: same frame with the last FCS byte XOR 0x01 -> halt_req = 1 one cycle after txen falls. A separate 40-byte frame with valid FCS also sets halt_req. txer pulse mid-frame sets halt_req.
- MDIO read, port 1 (PHYAD 2): read reg2 -> 0x5000 and reg3 -> 0x0000 on mdio[1]; reg0 -> 0x1140. mdio[0], mdio[2], mdio[3] are never driven.
- MDIO write then read back, port 0 (PHYAD 1): write reg4 = 0xA5A5 -> read 0xA5A5. Write reg0 = 0x8000 -> reg0 reads 0x1140 and reg4 still 0xA5A5.
- Abort/reset: ST = 00 after preamble -> no drive, no write. arst_n asserted mid-read -> mdio_en drops immediately and the next read returns correct data.
